// File: rtl/sevenseg_scan_pwm_if.sv
// sevenseg_scan_pwm_if: load-side bus between the bot I/O registers and the
// seven-segment scanner.
//   digits     : 5-bit code per digit, digit i at [5i+4:5i]
//   dp_in      : decimal point per digit, 1 = lit
//   blank_mask : 1 = digit forced dark
//   brightness : global PWM level, sampled every cycle
//   load       : one-cycle strobe capturing digits/dp_in/blank_mask
//   pending    : a captured load is waiting for the next frame boundary
// master = register side, slave = scanner.
interface sevenseg_scan_pwm_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PWM_BITS   = 4
);
  logic [5*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [PWM_BITS-1:0]     brightness;
  logic                    load;
  logic                    pending;

  modport master (
    output digits, dp_in, blank_mask, brightness, load,
    input  pending
  );

  modport slave (
    input  digits, dp_in, blank_mask, brightness, load,
    output pending
  );
endinterface

// File: rtl/sevenseg_scan_pwm.sv
// sevenseg_scan_pwm: time-multiplexed common-anode seven-segment driver with
// double-buffered loading, per-digit blanking, global PWM brightness and a
// dead time at the start of every digit slot.
//   clk, reset   : clock, asynchronous active-low reset
//   bus          : load-side interface (slave modport)
//   seg[6:0]     : cathodes {g,f,e,d,c,b,a}, active low
//   dp           : decimal-point cathode, active low
//   an           : anodes, active low, at most one low
//   frame_start  : one-cycle pulse as the digit index wraps to 0
module sevenseg_scan_pwm #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned DEAD_CYC   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_pwm_if.slave    bus,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int unsigned SUB_LEN = SCAN_DIV >> PWM_BITS;
  localparam int unsigned PRE_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned DIG_W   = 5 * NUM_DIGITS;

  // Active-low glyphs {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'h40;
      5'd1:    decode = 7'h79;
      5'd2:    decode = 7'h24;
      5'd3:    decode = 7'h30;
      5'd4:    decode = 7'h19;
      5'd5:    decode = 7'h12;
      5'd6:    decode = 7'h02;
      5'd7:    decode = 7'h78;
      5'd8:    decode = 7'h00;
      5'd9:    decode = 7'h10;
      5'd10:   decode = 7'h08;
      5'd11:   decode = 7'h03;
      5'd12:   decode = 7'h46;
      5'd13:   decode = 7'h21;
      5'd14:   decode = 7'h06;
      5'd15:   decode = 7'h0E;
      5'd17:   decode = 7'h3F;
      5'd18:   decode = 7'h0C;
      5'd19:   decode = 7'h23;
      default: decode = 7'h7F;
    endcase
  endfunction

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [PWM_BITS-1:0]   sub_q, sub_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [DIG_W-1:0]      act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_bl_q, act_bl_d, pend_bl_q, pend_bl_d;
  logic                  pending_q, pending_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  logic pre_wrap_c, sub_wrap_c, idx_wrap_c, frame_wrap_c;
  logic [4:0] code_c;
  logic       cur_dp_c, cur_bl_c, dead_c, en_c;

  assign pre_wrap_c   = (pre_q == PRE_W'(SUB_LEN - 1));
  assign sub_wrap_c   = (sub_q == '1);
  assign idx_wrap_c   = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap_c = pre_wrap_c && sub_wrap_c && idx_wrap_c;

  // Nested pre -> sub -> idx scan counters.
  always_comb begin
    pre_d = pre_q;
    sub_d = sub_q;
    idx_d = idx_q;
    if (pre_wrap_c) begin
      pre_d = '0;
      sub_d = sub_q + PWM_BITS'(1);
      if (sub_wrap_c) begin
        idx_d = idx_wrap_c ? '0 : idx_q + IDX_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Double buffer: promotion at the frame wrap reads the old pending contents,
  // so a load in the same cycle lands in pending and keeps the flag set.
  always_comb begin
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_bl_d   = act_bl_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_bl_d  = pend_bl_q;
    pending_d  = pending_q;
    if (frame_wrap_c && pending_q) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      act_bl_d  = pend_bl_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      pend_dig_d = bus.digits;
      pend_dp_d  = bus.dp_in;
      pend_bl_d  = bus.blank_mask;
      pending_d  = 1'b1;
    end
  end

  // Select the current digit from the active buffer.
  always_comb begin
    code_c   = '0;
    cur_dp_c = 1'b0;
    cur_bl_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        code_c   = act_dig_q[5*i +: 5];
        cur_dp_c = act_dp_q[i];
        cur_bl_c = act_bl_q[i];
      end
    end
  end

  // Dead time only in the first PWM sub-period of a slot.
  assign dead_c = (sub_q == '0) && (pre_q < PRE_W'(DEAD_CYC));
  assign en_c   = !cur_bl_c && !dead_c && (sub_q <= bus.brightness);

  // Pin drive, registered one cycle behind the counters.
  always_comb begin
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(en_c && (idx_q == IDX_W'(i)));
    end
    seg_d         = en_c ? decode(code_c) : 7'h7F;
    dp_d          = en_c ? !cur_dp_c : 1'b1;
    frame_start_d = frame_wrap_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q         <= '0;
      sub_q         <= '0;
      idx_q         <= '0;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      act_bl_q      <= '0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_bl_q     <= '0;
      pending_q     <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      sub_q         <= sub_d;
      idx_q         <= idx_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      act_bl_q      <= act_bl_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_bl_q     <= pend_bl_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_pwm.sv
// tb_sevenseg_scan_pwm: directed bench for sevenseg_scan_pwm with
// NUM_DIGITS=4, SCAN_DIV=32, PWM_BITS=2, DEAD_CYC=2 (128-cycle frame).
module tb_sevenseg_scan_pwm;
  localparam int unsigned ND    = 4;
  localparam int unsigned PB    = 2;
  localparam int          FRAME = 128;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  sevenseg_scan_pwm_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus_if ();

  sevenseg_scan_pwm #(
    .NUM_DIGITS(ND), .SCAN_DIV(32), .PWM_BITS(PB), .DEAD_CYC(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the frame position and both buffers.
  int         st;
  logic [4:0] m_act [4];
  logic [4:0] m_pb  [4];
  logic [3:0] m_act_dp, m_pb_dp, m_act_bl, m_pb_bl;
  logic       m_pend;
  int         edge_n, first_fs;
  int         lowcnt [4];

  // Lit segments {g,f,e,d,c,b,a}, 1 = on.
  function automatic logic [6:0] lit(input logic [4:0] c);
    case (c)
      5'd0:  return 7'h3F;  5'd1:  return 7'h06;  5'd2:  return 7'h5B;
      5'd3:  return 7'h4F;  5'd4:  return 7'h66;  5'd5:  return 7'h6D;
      5'd6:  return 7'h7D;  5'd7:  return 7'h07;  5'd8:  return 7'h7F;
      5'd9:  return 7'h6F;  5'd10: return 7'h77;  5'd11: return 7'h7C;
      5'd12: return 7'h39;  5'd13: return 7'h5E;  5'd14: return 7'h79;
      5'd15: return 7'h71;  5'd17: return 7'h40;  5'd18: return 7'h73;
      5'd19: return 7'h5C;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    st = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = '0;
      m_pb[i]  = '0;
    end
    m_act_dp = '0; m_pb_dp = '0; m_act_bl = '0; m_pb_bl = '0;
    m_pend   = 1'b0;
    edge_n   = 0;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 4; i++) lowcnt[i] = 0;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    int   idx, t, sub;
    logic en;
    idx = st / 32;
    t   = st % 32;
    sub = t / 8;
    en  = !m_act_bl[idx] && (t >= 2) && (sub <= int'(bus_if.brightness));
    e.an   = en ? ~(4'b0001 << idx) : 4'hF;
    e.seg  = en ? ~lit(m_act[idx]) : 7'h7F;
    e.dp   = en ? ~m_act_dp[idx] : 1'b1;
    e.fs   = (st == FRAME - 1);
    if (st == FRAME - 1 && m_pend) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_pb[i];
      m_act_dp = m_pb_dp;
      m_act_bl = m_pb_bl;
      m_pend   = 1'b0;
    end
    if (bus_if.load) begin
      for (int i = 0; i < 4; i++) m_pb[i] = bus_if.digits[5*i +: 5];
      m_pb_dp = bus_if.dp_in;
      m_pb_bl = bus_if.blank_mask;
      m_pend  = 1'b1;
    end
    e.pend = m_pend;
    st = (st + 1) % FRAME;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    e = sb_q.pop_front();
    chk("an", 32'(an), 32'(e.an));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dp", 32'(dp), 32'(e.dp));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("pending", 32'(bus_if.pending), 32'(e.pend));
    for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lowcnt[i]++;
    if (frame_start && first_fs < 0) first_fs = edge_n;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [19:0] dig, input logic [3:0] dpv, input logic [3:0] bl);
    bus_if.digits     = dig;
    bus_if.dp_in      = dpv;
    bus_if.blank_mask = bl;
    bus_if.load       = 1'b1;
    step();
    bus_if.load       = 1'b0;
  endtask

  task automatic chk_duty(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_d0"}, 32'(lowcnt[0]), 32'(e0));
    chk({tag, "_d1"}, 32'(lowcnt[1]), 32'(e1));
    chk({tag, "_d2"}, 32'(lowcnt[2]), 32'(e2));
    chk({tag, "_d3"}, 32'(lowcnt[3]), 32'(e3));
  endtask

  initial begin
    reset             = 1'b0;
    bus_if.digits     = '0;
    bus_if.dp_in      = '0;
    bus_if.blank_mask = '0;
    bus_if.brightness = 2'b11;
    bus_if.load       = 1'b0;
    first_fs          = -1;
    model_reset();
    clear_cnt();

    // Held in reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'(4'hF));
    chk("rst_seg", 32'(seg), 32'(7'h7F));
    chk("rst_dp", 32'(dp), 32'(1'b1));
    chk("rst_fs", 32'(frame_start), 32'(1'b0));
    chk("rst_pending", 32'(bus_if.pending), 32'(1'b0));

    // Frame 0: release, first lit cycle, mid-frame load.
    reset = 1'b1;
    model_reset();
    clear_cnt();
    run(3);
    chk("an0_cycle3", 32'(an), 32'(4'b1110));
    chk("seg0_cycle3", 32'(seg), 32'(7'b1000000));
    run(37);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0001, 4'b0000);
    chk("pending_after_load", 32'(bus_if.pending), 32'(1'b1));
    run(87);
    chk("first_fs_cycle", 32'(first_fs), 32'(128));
    chk("pending_after_wrap", 32'(bus_if.pending), 32'(1'b0));
    chk_duty("duty_f0_b3", 30, 30, 30, 30);

    // Frame 1: new digits active.
    clear_cnt();
    run(3);
    chk("f1_d0_an", 32'(an), 32'(4'b1110));
    chk("f1_d0_dp", 32'(dp), 32'(1'b0));
    run(32);
    chk("f1_d1_an", 32'(an), 32'(4'b1101));
    chk("f1_d1_seg", 32'(seg), 32'(7'b1111001));
    run(93);
    chk_duty("duty_f1_b3", 30, 30, 30, 30);

    // Frame 2: minimum brightness, load a blank mask.
    bus_if.brightness = 2'b00;
    clear_cnt();
    run(20);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0001, 4'b0100);
    run(107);
    chk_duty("duty_f2_b0", 6, 6, 6, 6);

    // Frame 3: full brightness, digit 2 blanked.
    bus_if.brightness = 2'b11;
    clear_cnt();
    run(128);
    chk_duty("duty_f3_blank", 30, 30, 0, 30);

    // Frame 4: A pending, then B loaded on the wrap cycle itself.
    run(50);
    do_load({5'd19, 5'd18, 5'd17, 5'd16}, 4'b0000, 4'b0000);
    run(76);
    do_load({5'd15, 5'd14, 5'd13, 5'd12}, 4'b1010, 4'b0000);
    chk("coincident_fs", 32'(frame_start), 32'(1'b1));
    chk("coincident_pending", 32'(bus_if.pending), 32'(1'b1));

    // Frame 5: A active, B promoted at its end.
    run(128);
    chk("b_promoted_pending", 32'(bus_if.pending), 32'(1'b0));

    // Frame 6: B active ('C' on digit 0, dp off).
    run(3);
    chk("f6_d0_seg", 32'(seg), 32'(7'h46));
    chk("f6_d0_dp", 32'(dp), 32'(1'b1));
    run(125);

    // Frame 7: reset in slot 2 while a load is pending.
    run(10);
    do_load({5'd8, 5'd8, 5'd8, 5'd8}, 4'hF, 4'h0);
    run(60);
    chk("pre_reset_pending", 32'(bus_if.pending), 32'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'(4'hF));
    chk("async_rst_seg", 32'(seg), 32'(7'h7F));
    chk("async_rst_dp", 32'(dp), 32'(1'b1));
    chk("async_rst_pending", 32'(bus_if.pending), 32'(1'b0));
    chk("async_rst_fs", 32'(frame_start), 32'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    clear_cnt();
    run(3);
    chk("restart_an", 32'(an), 32'(4'b1110));
    chk("restart_seg", 32'(seg), 32'(7'h40));
    run(255);
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
